// File: rtl/rv32i_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_test_ctrl
// Description : Regression sequencer for the rv32i core. Holds the core in
//               reset, releases it for one test run, watches the data-memory
//               write port for the riscv-tests "tohost" exit write, bounds
//               each run with a watchdog and tallies pass/fail over
//               NUM_TESTS runs.
// Optional    : `define TEST_CTRL_STOP_ON_FAIL_EN stops the regression at
//               the first failing (or timed-out) run.
// Ports       : clk, rst (async, active-high)
//               start_i                          begin regression (IDLE/DONE)
//               mem_we_i/mem_addr_i/mem_wdata_i  core data write port
//               core_rst_o                       reset to the core
//               busy_o, done_o                   sequencer status
//               test_idx_o                       current / last run index
//               pass_cnt_o, fail_cnt_o           regression tallies
//               result_valid_o/_pass_o/_timeout_o/_code_o  per-run result
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_test_ctrl #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          NUM_TESTS      = 16,
  parameter int          RST_HOLD       = 8,
  localparam int         IW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int         CW = $clog2(NUM_TESTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          mem_we_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [31:0]   mem_wdata_i,
  output logic          core_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] test_idx_o,
  output logic [CW-1:0] pass_cnt_o,
  output logic [CW-1:0] fail_cnt_o,
  output logic          result_valid_o,
  output logic          result_pass_o,
  output logic          result_timeout_o,
  output logic [30:0]   result_code_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_TESTS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_RECORD = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] test_idx_q, test_idx_d;
  logic [CW-1:0] pass_cnt_q, pass_cnt_d;
  logic [CW-1:0] fail_cnt_q, fail_cnt_d;
  logic          res_pass_q, res_pass_d;
  logic          res_timeout_q, res_timeout_d;
  logic [30:0]   res_code_q, res_code_d;
  logic          core_rst_q, core_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          res_valid_q, res_valid_d;
  logic          exit_write;
  logic          stop_now;

  // Only odd tohost values terminate a test; even values are console/syscall
  // traffic in the riscv-tests convention and must be ignored.
  assign exit_write = mem_we_i && (mem_addr_i == TOHOST_ADDR) && mem_wdata_i[0];

`ifdef TEST_CTRL_STOP_ON_FAIL_EN
  assign stop_now = (test_idx_q == IDX_LAST) || !res_pass_q;
`else
  assign stop_now = (test_idx_q == IDX_LAST);
`endif

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    timer_d       = timer_q;
    test_idx_d    = test_idx_q;
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    res_pass_d    = res_pass_q;
    res_timeout_d = res_timeout_q;
    res_code_d    = res_code_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          test_idx_d = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        timer_d = timer_q + TW'(1);
        // Exit write is checked first so it wins over a same-cycle timeout.
        if (exit_write) begin
          state_d       = ST_RECORD;
          res_pass_d    = (mem_wdata_i == 32'd1);
          res_timeout_d = 1'b0;
          res_code_d    = mem_wdata_i[31:1];
        end else if (timer_q == TIMER_LAST) begin
          state_d       = ST_RECORD;
          res_pass_d    = 1'b0;
          res_timeout_d = 1'b1;
          res_code_d    = '0;
        end
      end
      ST_RECORD: begin
        if (res_pass_q) pass_cnt_d = pass_cnt_q + CW'(1);
        else            fail_cnt_d = fail_cnt_q + CW'(1);
        if (stop_now) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_HOLD;
          test_idx_d = test_idx_q + IW'(1);
          hold_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    core_rst_d  = (state_d != ST_RUN);
    busy_d      = (state_d == ST_HOLD) || (state_d == ST_RUN) || (state_d == ST_RECORD);
    done_d      = (state_d == ST_DONE);
    res_valid_d = (state_d == ST_RECORD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      timer_q       <= '0;
      test_idx_q    <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      res_pass_q    <= 1'b0;
      res_timeout_q <= 1'b0;
      res_code_q    <= '0;
      core_rst_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      timer_q       <= timer_d;
      test_idx_q    <= test_idx_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      res_pass_q    <= res_pass_d;
      res_timeout_q <= res_timeout_d;
      res_code_q    <= res_code_d;
      core_rst_q    <= core_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign core_rst_o       = core_rst_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign test_idx_o       = test_idx_q;
  assign pass_cnt_o       = pass_cnt_q;
  assign fail_cnt_o       = fail_cnt_q;
  assign result_valid_o   = res_valid_q;
  assign result_pass_o    = res_pass_q;
  assign result_timeout_o = res_timeout_q;
  assign result_code_o    = res_code_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_test_ctrl
// Description : Self-checking bench for rv32i_test_ctrl (TIMEOUT_CYCLES=50,
//               other parameters at default). Expected per-run results are
//               queued when the exit stimulus is driven and compared when
//               result_valid_o pulses. Honours TEST_CTRL_STOP_ON_FAIL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_test_ctrl;

  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        core_rst_o, busy_o, done_o;
  logic [3:0]  test_idx_o;
  logic [4:0]  pass_cnt_o, fail_cnt_o;
  logic        result_valid_o, result_pass_o, result_timeout_o;
  logic [30:0] result_code_o;

  int checks = 0;
  int failures = 0;
  int exp_pass = 0;
  int exp_fail = 0;

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [30:0] code;
  } exp_t;
  exp_t sb[$];

  rv32i_test_ctrl #(
    .TOHOST_ADDR   (TOHOST),
    .TIMEOUT_CYCLES(50),
    .NUM_TESTS     (16),
    .RST_HOLD      (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .mem_we_i        (mem_we_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .core_rst_o      (core_rst_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .test_idx_o      (test_idx_o),
    .pass_cnt_o      (pass_cnt_o),
    .fail_cnt_o      (fail_cnt_o),
    .result_valid_o  (result_valid_o),
    .result_pass_o   (result_pass_o),
    .result_timeout_o(result_timeout_o),
    .result_code_o   (result_code_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every result pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (!rst && result_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(result_valid_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_pass",    32'(result_pass_o),    32'(e.pass));
        chk("res_timeout", 32'(result_timeout_o), 32'(e.timeout));
        chk("res_code",    32'(result_code_o),    32'(e.code));
      end
    end
  end

  task automatic write_cycle(input logic we, input logic [31:0] addr, input logic [31:0] data);
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_wdata_i = data;
    @(negedge clk);
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
  endtask

  task automatic do_exit(input logic [31:0] data);
    exp_t e;
    e.pass    = (data == 32'd1);
    e.timeout = 1'b0;
    e.code    = data[31:1];
    sb.push_back(e);
    if (e.pass) exp_pass++; else exp_fail++;
    write_cycle(1'b1, TOHOST, data);
  endtask

  task automatic push_timeout();
    exp_t e;
    e.pass = 1'b0; e.timeout = 1'b1; e.code = '0;
    sb.push_back(e);
    exp_fail++;
  endtask

  // Returns at the negedge of the first RUN cycle.
  task automatic wait_run(input int idx);
    int n = 0;
    while (core_rst_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_run", 32'(core_rst_o), 32'd0);
    chk("run_busy", 32'(busy_o), 32'd1);
    chk("run_idx",  32'(test_idx_o), 32'(idx));
  endtask

  task automatic finish_run();
    int n = 0;
    while (!result_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("result_seen",  32'(result_valid_o), 32'd1);
    chk("record_rst",   32'(core_rst_o), 32'd1);
    @(negedge clk);
    chk("valid_pulse",  32'(result_valid_o), 32'd0);
    chk("pass_cnt",     32'(pass_cnt_o), 32'(exp_pass));
    chk("fail_cnt",     32'(fail_cnt_o), 32'(exp_fail));
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #10;
    chk("rst_core_rst", 32'(core_rst_o), 32'd1);
    chk("rst_busy",     32'(busy_o), 32'd0);
    chk("rst_done",     32'(done_o), 32'd0);
    chk("rst_idx",      32'(test_idx_o), 32'd0);
    chk("rst_pass",     32'(pass_cnt_o), 32'd0);
    chk("rst_fail",     32'(fail_cnt_o), 32'd0);
    chk("rst_valid",    32'(result_valid_o), 32'd0);
    chk("rst_rpass",    32'(result_pass_o), 32'd0);
    chk("rst_rtmo",     32'(result_timeout_o), 32'd0);
    chk("rst_code",     32'(result_code_o), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Start: exactly 8 HOLD cycles with core reset asserted, then RUN
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("hold_core_rst", 32'(core_rst_o), 32'd1);
      chk("hold_busy",     32'(busy_o), 32'd1);
      @(negedge clk);
    end
    chk("run_core_rst", 32'(core_rst_o), 32'd0);

    // Run 0: pass
    wait_run(0);
    repeat (2) @(negedge clk);
    do_exit(32'h1);
    finish_run();

    // Run 1: ignored writes, then fail with code 3
    wait_run(1);
    write_cycle(1'b1, TOHOST, 32'h6);
    write_cycle(1'b1, TOHOST + 32'd4, 32'h1);
    chk("ignored_writes", 32'(result_valid_o), 32'd0);
    do_exit(32'h7);
    finish_run();

`ifdef TEST_CTRL_STOP_ON_FAIL_EN
    chk("sof_done", 32'(done_o), 32'd1);
    chk("sof_idx",  32'(test_idx_o), 32'd1);
    chk("sof_pass", 32'(pass_cnt_o), 32'd1);
    chk("sof_fail", 32'(fail_cnt_o), 32'd1);
`else
    // Run 2: timeout on RUN cycle 50
    wait_run(2);
    push_timeout();
    repeat (49) @(negedge clk);
    chk("tmo_not_early", 32'(result_valid_o), 32'd0);
    chk("tmo_still_run", 32'(core_rst_o), 32'd0);
    @(negedge clk);
    chk("tmo_fires", 32'(result_valid_o), 32'd1);
    finish_run();

    // Run 3: exit write on RUN cycle 50 beats the timeout
    wait_run(3);
    repeat (49) @(negedge clk);
    do_exit(32'h1);
    finish_run();

    // Runs 4..15: alternate pass / fail with code = run index
    for (int i = 4; i < 16; i++) begin
      wait_run(i);
      repeat (3) @(negedge clk);
      if (i % 2 == 0) do_exit(32'h1);
      else            do_exit((32'(i) << 1) | 32'd1);
      finish_run();
    end
    chk("reg_done",     32'(done_o), 32'd1);
    chk("reg_busy",     32'(busy_o), 32'd0);
    chk("reg_core_rst", 32'(core_rst_o), 32'd1);
    chk("reg_idx",      32'(test_idx_o), 32'd15);
    chk("reg_pass",     32'(pass_cnt_o), 32'd8);
    chk("reg_fail",     32'(fail_cnt_o), 32'd8);
    repeat (3) @(negedge clk);
    chk("done_hold_pass", 32'(pass_cnt_o), 32'd8);
    chk("done_hold_done", 32'(done_o), 32'd1);
`endif

    // Restart from DONE clears the tallies
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("restart_pass", 32'(pass_cnt_o), 32'd0);
    chk("restart_fail", 32'(fail_cnt_o), 32'd0);
    chk("restart_idx",  32'(test_idx_o), 32'd0);
    chk("restart_busy", 32'(busy_o), 32'd1);
    chk("restart_done", 32'(done_o), 32'd0);
    exp_pass = 0;
    exp_fail = 0;

    // Asynchronous reset in the middle of RUN
    wait_run(0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_core_rst", 32'(core_rst_o), 32'd1);
    chk("mid_busy",     32'(busy_o), 32'd0);
    chk("mid_done",     32'(done_o), 32'd0);
    chk("mid_idx",      32'(test_idx_o), 32'd0);
    chk("mid_pass",     32'(pass_cnt_o), 32'd0);
    chk("mid_fail",     32'(fail_cnt_o), 32'd0);
    chk("mid_valid",    32'(result_valid_o), 32'd0);
    chk("mid_rpass",    32'(result_pass_o), 32'd0);
    chk("mid_rtmo",     32'(result_timeout_o), 32'd0);
    chk("mid_code",     32'(result_code_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_idle", 32'(core_rst_o), 32'd1);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("sb_empty",      32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32i_test_ctrl.md
# rv32i_test_ctrl

Synthesizable regression sequencer for the rv32i core in simulation and FPGA bring-up. It holds the core in reset, releases it for one test run, and watches the core's data-memory write port for the riscv-tests "tohost" exit write. It bounds each run with a watchdog and tallies pass and fail results over a fixed number of runs. Benches read the counters and per-run result pulses instead of post-processing log text.

## Interface
Parameters:
- TOHOST_ADDR, 32'h8000_1000, byte address of the tohost word.
- TIMEOUT_CYCLES, 100000, maximum RUN cycles per test (≥2).
- NUM_TESTS, 16, runs per regression (≥1).
- RST_HOLD, 8, cycles core reset is held before each run (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  begin regression; sampled only in IDLE or DONE.
- mem_we_i  in  1  core data-memory write strobe.
- mem_addr_i  in  32  core data-memory write address.
- mem_wdata_i  in  32  core data-memory write data.
- core_rst_o  out  1  reset to the core, active-high.
- busy_o  out  1  high in HOLD, RUN or RECORD.
- done_o  out  1  high in DONE.
- test_idx_o  out  IW=max(1,$clog2(NUM_TESTS))  index of the current or last run.
- pass_cnt_o  out  CW=$clog2(NUM_TESTS+1)  runs passed.
- fail_cnt_o  out  CW  runs failed, including timeouts.
- result_valid_o  out  1  one-cycle pulse per finished run.
- result_pass_o  out  1  qualified by result_valid_o.
- result_timeout_o  out  1  qualified by result_valid_o.
- result_code_o  out  31  exit code of the last run; 0 on pass or timeout.

## Operation
- States: IDLE, HOLD, RUN, RECORD, DONE.
- IDLE: core_rst_o=1. On start_i, clear the counters, test_idx_o and the hold counter, then go to HOLD.
- HOLD: core_rst_o=1. After RST_HOLD cycles, go to RUN and clear the watchdog timer.
- RUN: core_rst_o=0. The timer increments every cycle.
  - An exit write is mem_we_i=1, mem_addr_i==TOHOST_ADDR and mem_wdata_i[0]=1.
  - On an exit write, pass = (mem_wdata_i==1) and code = mem_wdata_i[31:1]. Latch both and go to RECORD.
  - Writes to TOHOST_ADDR with mem_wdata_i[0]=0 are ignored.
  - When the timer equals TIMEOUT_CYCLES-1 with no exit write in that cycle, latch fail, timeout=1, code=0, and go to RECORD.
  - An exit write in the same cycle as the timeout wins.
- RECORD (one cycle): core_rst_o=1 and result_valid_o=1. Increment pass_cnt_o or fail_cnt_o.
  - If test_idx_o==NUM_TESTS-1, go to DONE.
  - Otherwise increment test_idx_o and go to HOLD.
- DONE: core_rst_o=1 and done_o=1. Counters hold. start_i restarts exactly as from IDLE.
- start_i is ignored in HOLD, RUN and RECORD.
- Counters cannot overflow, because the count is bounded by NUM_TESTS.

## Timing
- Reset values: state=IDLE, core_rst_o=1, busy_o=0, done_o=0, test_idx_o=0, pass_cnt_o=0, fail_cnt_o=0, result_valid_o=0, result_pass_o=0, result_timeout_o=0, result_code_o=0.
- All outputs are registered.
- Asserting rst mid-run returns every output to its reset value immediately. No result is produced for the interrupted run.
- Start latency: start_i high at edge N gives HOLD from N+1. core_rst_o falls at edge N+1+RST_HOLD.
- Exit write at edge M: result_valid_o is high for cycle M+1 (RECORD), and counters update at edge M+2. For a non-final run, core_rst_o is high from M+1 and HOLD begins at M+2.
- Timeout fires on RUN cycle TIMEOUT_CYCLES, counting the first RUN cycle as 1.
- Gap between runs: RECORD (1 cycle) plus HOLD (RST_HOLD cycles).

## Configuration
- TEST_CTRL_STOP_ON_FAIL_EN defined: a RECORD cycle with fail (including timeout) goes to DONE regardless of test_idx_o. test_idx_o keeps the failing index.
- Macro undefined: all NUM_TESTS runs execute regardless of failures.

## Test plan
Defaults throughout, except TIMEOUT_CYCLES=50 where noted.
- Reset and start: pulse start_i → core_rst_o=1 for 8 cycles, then 0. busy_o=1 and test_idx_o=0.
- Pass run: write 32'h1 to 32'h8000_1000 → result_valid_o pulse with result_pass_o=1 and result_code_o=0. pass_cnt_o=1.
- Fail code: write 32'h7 → result_pass_o=0 and result_code_o=3. fail_cnt_o=1. A prior write of 32'h6 to the same address is ignored, and a write of 32'h1 to 32'h8000_1004 is ignored.
- Timeout (TIMEOUT_CYCLES=50): no exit write → result_timeout_o=1 on RUN cycle 50. An exit write on cycle 50 instead counts as the result, with result_timeout_o=0.
- Full regression: 16 runs alternating pass and fail → done_o=1, pass_cnt_o=8, fail_cnt_o=8, test_idx_o=15. A new start_i clears both counters. With TEST_CTRL_STOP_ON_FAIL_EN defined, run 1 failing gives done_o=1 with test_idx_o=1, pass_cnt_o=1, fail_cnt_o=1.
- Reset mid-RUN: assert rst → all outputs return to reset values immediately, and core_rst_o=1.
